// File: rtl/memory_16byte.sv
`default_nettype none
// ============================================================================
//  Module      : memory_16byte
//  Description : 16 x 8 single-port RAM on a shared bidirectional data bus.
//                Synchronous reset/preset clear or fill the whole array,
//                writes are synchronous, reads are combinational and drive
//                the bus only while read=1 and write=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_16byte #(
    parameter int                  DATA_WIDTH   = 8,
    parameter int                  ADDR_WIDTH   = 4,
    parameter int                  DEPTH        = 16,
    parameter logic [DATA_WIDTH-1:0] PRESET_VALUE = 8'hFF,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = 8'h00
) (
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  clk,
    input  logic                  read,
    input  logic                  write,
    input  logic                  preset,
    input  logic                  reset
);

    // Storage array; its contents are the only state in this block.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Read and write qualifiers. Asserting both strobes together is treated
    // as a no-op: nothing is written and the bus stays released, so neither
    // side drives and there is no contention.
    logic w_read_en;
    logic w_write_en;

    assign w_read_en  = read  & ~write;
    assign w_write_en = write & ~read;

    // Array update: reset beats preset, and both beat a pending write.
    // A write that coincides with reset/preset is dropped for that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VALUE;
            end
        end else if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= PRESET_VALUE;
            end
        end else if (w_write_en) begin
            r_mem[address] <= data;
        end
    end

    // Zero-latency read path. The output enable depends only on the strobes,
    // so a read during reset/preset shows the array contents before the edge
    // and the new contents right after it.
    assign data = w_read_en ? r_mem[address] : {DATA_WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_memory_16byte.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_16byte
//  Description : Self-checking bench for memory_16byte. Stimulus pushes the
//                expected bus value into a queue; a monitor samples the bus
//                mid-cycle and compares against the popped expectation.
//                The bus has weak pull-downs, so a released bus reads 8'h00.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_16byte;

    localparam int             c_dw = 8;
    localparam int             c_aw = 4;
    localparam logic [c_dw-1:0] c_preset = 8'hFF;
    localparam logic [c_dw-1:0] c_reset  = 8'h00;

    logic            clk;
    logic            reset;
    logic            preset;
    logic            read;
    logic            write;
    logic [c_aw-1:0] address;
    logic [c_dw-1:0] drv;
    logic            drv_en;
    wire  [c_dw-1:0] data;

    // Bus master driver: only drives during a legal write.
    assign data = drv_en ? drv : {c_dw{1'bz}};

    // Weak pull-downs so a released bus has a defined value in every simulator.
    for (genvar gi = 0; gi < c_dw; gi++) begin : g_pd
        pulldown (data[gi]);
    end

    memory_16byte dut (
        .data    (data),
        .address (address),
        .clk     (clk),
        .read    (read),
        .write   (write),
        .preset  (preset),
        .reset   (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [c_dw-1:0] exp;
        logic [c_aw-1:0] addr;
        string           kind;
    } exp_t;

    exp_t            sb_q[$];
    logic [c_dw-1:0] model [16];
    int              checks;
    int              errors;
    bit              stim_done;

    // One bus cycle: drive inputs after the falling edge, record what the bus
    // must show for the rest of the cycle, then apply the spec's update rule
    // to the model for the coming rising edge.
    task automatic step(input bit rst, input bit pre, input bit rd, input bit wr,
                        input logic [c_aw-1:0] a, input logic [c_dw-1:0] wd);
        exp_t e;
        @(negedge clk);
        reset   = rst;
        preset  = pre;
        read    = rd;
        write   = wr;
        address = a;
        drv     = wd;
        drv_en  = wr && !rd;
        e.addr  = a;
        if (rd && !wr) begin
            e.exp  = model[a];
            e.kind = "read";
        end else if (wr && !rd) begin
            e.exp  = wd;
            e.kind = "wbus";
        end else begin
            e.exp  = '0;
            e.kind = "hiz";
        end
        sb_q.push_back(e);
        if (rst) begin
            foreach (model[i]) model[i] = c_reset;
        end else if (pre) begin
            foreach (model[i]) model[i] = c_preset;
        end else if (wr && !rd) begin
            model[a] = wd;
        end
    endtask

    // Monitor: sample mid-way through the low phase, well away from posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (data !== e.exp) begin
                    errors++;
                    $display("FAIL %s addr=%0d: got %h, expected %h at %0t",
                             e.kind, e.addr, data, e.exp, $time);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: stimulus not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        stim_done = 1'b0;
        reset = 1'b0; preset = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; drv = '0; drv_en = 1'b0;
        foreach (model[i]) model[i] = '0;

        // Reset, then read back cleared words.
        step(1, 0, 0, 0, 4'd0, 8'h00);
        step(0, 0, 1, 0, 4'd0, 8'h00);
        step(0, 0, 1, 0, 4'd2, 8'h00);
        step(0, 0, 1, 0, 4'd4, 8'h00);
        // Preset, then read filled words.
        step(0, 1, 0, 0, 4'd0, 8'h00);
        step(0, 0, 1, 0, 4'd0, 8'h00);
        step(0, 0, 1, 0, 4'd15, 8'h00);
        // Write and read back.
        step(0, 0, 0, 1, 4'd2, 8'h24);
        step(0, 0, 0, 1, 4'd4, 8'h81);
        step(0, 0, 1, 0, 4'd2, 8'h00);
        step(0, 0, 1, 0, 4'd4, 8'h00);
        step(0, 0, 1, 0, 4'd0, 8'h00);
        // Illegal strobe pair: bus released, no write.
        step(0, 0, 1, 1, 4'd2, 8'h09);
        step(0, 0, 1, 0, 4'd2, 8'h00);
        // Reset clears earlier writes.
        step(1, 0, 0, 0, 4'd0, 8'h00);
        step(0, 0, 1, 0, 4'd4, 8'h00);
        step(0, 0, 1, 0, 4'd2, 8'h00);
        // Priority of preset/reset over a simultaneous write.
        step(0, 1, 0, 1, 4'd3, 8'h5A);
        step(0, 0, 1, 0, 4'd3, 8'h00);
        step(0, 0, 0, 0, 4'd3, 8'h00);
        step(1, 0, 0, 1, 4'd3, 8'h5A);
        step(0, 0, 1, 0, 4'd3, 8'h00);
        // Idle with nonzero contents: bus must stay released.
        step(0, 1, 0, 0, 4'd3, 8'h00);
        step(0, 0, 0, 0, 4'd3, 8'h00);
        step(0, 0, 0, 0, 4'd9, 8'h00);
        // Held write rewrites the same word; address-follow on reads.
        step(0, 0, 0, 1, 4'd7, 8'h11);
        step(0, 0, 0, 1, 4'd7, 8'h22);
        step(0, 0, 1, 0, 4'd7, 8'h00);
        step(0, 0, 1, 0, 4'd8, 8'h00);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            bit rst, pre, rd, wr;
            rst = ($urandom_range(0, 39) == 0);
            pre = ($urandom_range(0, 29) == 0);
            rd  = $urandom_range(0, 1);
            wr  = $urandom_range(0, 1);
            step(rst, pre, rd, wr, 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)));
        end

        step(0, 0, 0, 0, 4'd0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        #4;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
        end
        stim_done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
